bf_program_loader: RTL and testbench

//  Writer side of the program-memory opcode interface: accepts an ASCII Brainfuck source stream byte by byte (valid/ready).

---
 rtl/bf_pkg.sv | 48 ++++
 rtl/bf_char_encoder.sv | 32 +++
 rtl/bf_program_loader.sv | 201 ++++++++++++++++++++
 tb/tb_bf_program_loader.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bf_pkg.sv
// Purpose : shared Brainfuck opcode, ASCII and loader-state constants.
// Latency : none (constants and types only).
// Backpressure: none.
//
// Shared by the program loader and the machine control FSM so both ends of
// the program memory agree on the 4-bit opcode encoding.
// Contents:
//   OP_*      4-bit opcodes written into program memory (OP_STOP ends a program)
//   ASCII_*   source characters that map onto those opcodes
//   LD_*      loader FSM state codes
//   enc_t     result of classifying one source byte
package bf_pkg;

  // Program memory opcodes.
  localparam logic [3:0] OP_LT    = 4'h0;  // '<'
  localparam logic [3:0] OP_GT    = 4'h1;  // '>'
  localparam logic [3:0] OP_INC   = 4'h2;  // '+'
  localparam logic [3:0] OP_DEC   = 4'h3;  // '-'
  localparam logic [3:0] OP_LOOP  = 4'h4;  // '['
  localparam logic [3:0] OP_END   = 4'h5;  // ']'
  localparam logic [3:0] OP_OUT   = 4'h6;  // '.'
  localparam logic [3:0] OP_IN    = 4'h7;  // ','
  localparam logic [3:0] OP_STOP  = 4'hF;

  // ASCII source characters.
  localparam logic [7:0] ASCII_LT     = 8'h3C;
  localparam logic [7:0] ASCII_GT     = 8'h3E;
  localparam logic [7:0] ASCII_PLUS   = 8'h2B;
  localparam logic [7:0] ASCII_MINUS  = 8'h2D;
  localparam logic [7:0] ASCII_LBRACK = 8'h5B;
  localparam logic [7:0] ASCII_RBRACK = 8'h5D;
  localparam logic [7:0] ASCII_DOT    = 8'h2E;
  localparam logic [7:0] ASCII_COMMA  = 8'h2C;

  // Loader FSM state codes.
  localparam logic [2:0] LD_IDLE = 3'd0;
  localparam logic [2:0] LD_LOAD = 3'd1;
  localparam logic [2:0] LD_TERM = 3'd2;
  localparam logic [2:0] LD_DONE = 3'd3;
  localparam logic [2:0] LD_ERR  = 3'd4;

  // Classification of one source byte.
  typedef struct packed {
    logic       is_cmd;  // byte is one of the eight commands
    logic [3:0] opcode;  // valid only when is_cmd
  } enc_t;

endpackage

// File: rtl/bf_char_encoder.sv
// Purpose : map one ASCII source byte onto a program-memory opcode.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of char_data.
//
// Ports:
//   char_data  in   8   ASCII source byte
//   enc        out  5   {is_cmd, opcode}; non-command bytes give is_cmd=0
module bf_char_encoder
  import bf_pkg::*;
(
  input  logic [7:0] char_data,
  output enc_t       enc
);

  always_comb begin
    enc.is_cmd = 1'b1;
    enc.opcode = OP_STOP;
    case (char_data)
      ASCII_LT:     enc.opcode = OP_LT;
      ASCII_GT:     enc.opcode = OP_GT;
      ASCII_PLUS:   enc.opcode = OP_INC;
      ASCII_MINUS:  enc.opcode = OP_DEC;
      ASCII_LBRACK: enc.opcode = OP_LOOP;
      ASCII_RBRACK: enc.opcode = OP_END;
      ASCII_DOT:    enc.opcode = OP_OUT;
      ASCII_COMMA:  enc.opcode = OP_IN;
      // Whitespace and comment text are accepted but never written.
      default:      enc.is_cmd = 1'b0;
    endcase
  end

endmodule

// File: rtl/bf_program_loader.sv
// Purpose : load an ASCII Brainfuck byte stream into program memory as opcodes, ending with stop.
// Latency : an accepted command byte is written one cycle later; stop follows on the next cycle.
// Backpressure: char_ready is high only in LOAD and drops in a cycle that carries load_start.
//
// Optional build macro: BF_BRACKET_CHECK_EN enables bracket depth tracking and err_unbal.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   load_start          pulse: restart loading at address 0
//   char_valid/_data/_last/char_ready   source byte stream (valid/ready)
//   prog_we/_addr/_din  program memory write port (one pulse per opcode)
//   machine_hold        keeps the machine in reset while loading or after an error
//   done                program plus stop written
//   err_full            program did not fit with its stop opcode
//   err_unbal           unbalanced brackets (always 0 without BF_BRACKET_CHECK_EN)
//   prog_len            opcodes written, excluding stop
module bf_program_loader
  import bf_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned NEST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              char_valid,
  input  logic [7:0]        char_data,
  input  logic              char_last,
  output logic              char_ready,
  output logic              prog_we,
  output logic [ADDR_W-1:0] prog_addr,
  output logic [3:0]        prog_din,
  output logic              machine_hold,
  output logic              done,
  output logic              err_full,
  output logic              err_unbal,
  output logic [ADDR_W-1:0] prog_len
);

  // Highest address; reserved for the stop opcode.
  localparam logic [ADDR_W-1:0] LAST_SLOT = {ADDR_W{1'b1}};

  logic [2:0]        state_q,     state_d;
  logic [ADDR_W-1:0] wr_ptr_q,    wr_ptr_d;
  logic              prog_we_q,   prog_we_d;
  logic [ADDR_W-1:0] prog_addr_q, prog_addr_d;
  logic [3:0]        prog_din_q,  prog_din_d;
  logic              done_q,      done_d;
  logic              err_full_q,  err_full_d;
  logic [ADDR_W-1:0] prog_len_q,  prog_len_d;

  enc_t enc;
  logic restart;        // load_start honoured this cycle
  logic accept;         // byte handshake completes this cycle
  logic full_fault;     // command byte would overwrite the stop slot
  logic bracket_fault;  // accepted byte breaks bracket balance

  bf_char_encoder u_enc (
    .char_data (char_data),
    .enc       (enc)
  );

  // TERM lasts a single cycle and always completes its stop write, so a
  // load_start landing there is ignored.
  assign restart    = load_start && (state_q != LD_TERM);
  assign char_ready = (state_q == LD_LOAD) && !load_start;
  assign accept     = char_ready && char_valid;
  assign full_fault = accept && enc.is_cmd && (wr_ptr_q == LAST_SLOT);

`ifdef BF_BRACKET_CHECK_EN
  logic [NEST_W-1:0] depth_q, depth_d;
  logic              err_unbal_q, err_unbal_d;

  always_comb begin
    depth_d       = depth_q;
    bracket_fault = 1'b0;
    if (restart) begin
      depth_d = '0;
    end else if (accept) begin
      if (enc.is_cmd && enc.opcode == OP_LOOP) begin
        if (depth_q == '1) bracket_fault = 1'b1;
        else               depth_d = depth_q + NEST_W'(1);
      end else if (enc.is_cmd && enc.opcode == OP_END) begin
        if (depth_q == '0) bracket_fault = 1'b1;
        else               depth_d = depth_q - NEST_W'(1);
      end
      // An open loop at the end of the source is fatal; the final byte is
      // then not written either, so no write pulse ever overlaps ERR.
      if (char_last && !bracket_fault && depth_d != '0) bracket_fault = 1'b1;
    end
  end

  always_comb begin
    err_unbal_d = err_unbal_q;
    if (restart) begin
      err_unbal_d = 1'b0;
    end else if (accept && bracket_fault && !full_fault) begin
      err_unbal_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      depth_q     <= '0;
      err_unbal_q <= 1'b0;
    end else begin
      depth_q     <= depth_d;
      err_unbal_q <= err_unbal_d;
    end
  end

  assign err_unbal = err_unbal_q;
`else
  // Brackets are ordinary opcodes here; no depth is tracked.
  assign bracket_fault = 1'b0;
  assign err_unbal     = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    prog_we_d   = 1'b0;
    prog_addr_d = prog_addr_q;
    prog_din_d  = prog_din_q;
    done_d      = done_q;
    err_full_d  = err_full_q;
    prog_len_d  = prog_len_q;

    if (restart) begin
      // A byte presented alongside load_start is not accepted.
      state_d    = LD_LOAD;
      wr_ptr_d   = '0;
      done_d     = 1'b0;
      err_full_d = 1'b0;
      prog_len_d = '0;
    end else begin
      case (state_q)
        LD_LOAD: begin
          if (accept) begin
            if (full_fault) begin
              state_d    = LD_ERR;
              err_full_d = 1'b1;
            end else if (bracket_fault) begin
              state_d = LD_ERR;
            end else begin
              if (enc.is_cmd) begin
                prog_we_d   = 1'b1;
                prog_addr_d = wr_ptr_q;
                prog_din_d  = enc.opcode;
                wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
              end
              if (char_last) state_d = LD_TERM;
            end
          end
        end
        LD_TERM: begin
          // wr_ptr never exceeds LAST_SLOT here, so stop always fits.
          prog_we_d   = 1'b1;
          prog_addr_d = wr_ptr_q;
          prog_din_d  = OP_STOP;
          prog_len_d  = wr_ptr_q;
          done_d      = 1'b1;
          state_d     = LD_DONE;
        end
        LD_IDLE, LD_DONE, LD_ERR: ;
        default: state_d = LD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LD_IDLE;
      wr_ptr_q    <= '0;
      prog_we_q   <= 1'b0;
      prog_addr_q <= '0;
      prog_din_q  <= '0;
      done_q      <= 1'b0;
      err_full_q  <= 1'b0;
      prog_len_q  <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      prog_we_q   <= prog_we_d;
      prog_addr_q <= prog_addr_d;
      prog_din_q  <= prog_din_d;
      done_q      <= done_d;
      err_full_q  <= err_full_d;
      prog_len_q  <= prog_len_d;
    end
  end

  // An erroneous program stays held so the machine never executes it.
  assign machine_hold = (state_q == LD_LOAD) || (state_q == LD_TERM) || (state_q == LD_ERR);
  assign prog_we      = prog_we_q;
  assign prog_addr    = prog_addr_q;
  assign prog_din     = prog_din_q;
  assign done         = done_q;
  assign err_full     = err_full_q;
  assign prog_len     = prog_len_q;

endmodule

// File: tb/tb_bf_program_loader.sv
// Purpose : self-checking bench for bf_program_loader (default and small-memory instances).
// Latency : n/a.
// Backpressure: n/a.
module tb_bf_program_loader;

`ifdef BF_BRACKET_CHECK_EN
  localparam bit BCHK = 1'b1;
`else
  localparam bit BCHK = 1'b0;
`endif

  localparam int M_IDLE = 0, M_LOAD = 1, M_TERM = 2, M_DONE = 3, M_ERR = 4;

  logic clk = 1'b0, reset = 1'b1, load_start = 1'b0, char_valid = 1'b0, char_last = 1'b0;
  logic [7:0] char_data = 8'h00;

  logic rdy0, we0, hold0, done0, ef0, eu0;
  logic [7:0] addr0, len0;
  logic [3:0] din0;
  logic rdy1, we1, hold1, done1, ef1, eu1;
  logic [1:0] addr1, len1;
  logic [3:0] din1;

  bf_program_loader #(.ADDR_W(8), .NEST_W(8)) u_dut (
    .clk(clk), .reset(reset), .load_start(load_start), .char_valid(char_valid),
    .char_data(char_data), .char_last(char_last), .char_ready(rdy0), .prog_we(we0),
    .prog_addr(addr0), .prog_din(din0), .machine_hold(hold0), .done(done0),
    .err_full(ef0), .err_unbal(eu0), .prog_len(len0));

  bf_program_loader #(.ADDR_W(2), .NEST_W(8)) u_small (
    .clk(clk), .reset(reset), .load_start(load_start), .char_valid(char_valid),
    .char_data(char_data), .char_last(char_last), .char_ready(rdy1), .prog_we(we1),
    .prog_addr(addr1), .prog_din(din1), .machine_hold(hold1), .done(done1),
    .err_full(ef1), .err_unbal(eu1), .prog_len(len1));

  always #5 clk = ~clk;

  // Reference model: one entry per instance (0: 256 slots, 1: 4 slots).
  int mode[2], cnt[2], depth[2], m_len[2], m_addr[2], m_din[2];
  bit m_we[2], m_done[2], m_ef[2], m_eu[2];
  int obs0[$], obs1[$];
  int n_chk = 0, n_err = 0;
  bit chk_en = 1'b0;

  // Opcode is the character's position in the command alphabet.
  function automatic int cmd_index(input logic [7:0] c);
    string cmds;
    cmds = "<>+-[].,";
    for (int k = 0; k < 8; k++) if (cmds[k] == c) return k;
    return -1;
  endfunction

  task automatic emit(input int i, input int a, input int d);
    m_we[i] = 1'b1; m_addr[i] = a; m_din[i] = d;
  endtask

  task automatic take_byte(input int i);
    int slots, op, nd;
    bit unbal;
    slots = (i == 0) ? 256 : 4;
    op    = cmd_index(char_data);
    nd    = depth[i];
    unbal = 1'b0;
    if (BCHK) begin
      if (op == 4) begin if (depth[i] == 255) unbal = 1'b1; else nd++; end
      if (op == 5) begin if (depth[i] == 0) unbal = 1'b1; else nd--; end
      if (char_last && !unbal && nd != 0) unbal = 1'b1;
    end
    if (op >= 0 && cnt[i] == slots - 1) begin
      mode[i] = M_ERR; m_ef[i] = 1'b1;
    end else if (unbal) begin
      mode[i] = M_ERR; m_eu[i] = 1'b1;
    end else begin
      depth[i] = nd;
      if (op >= 0) begin emit(i, cnt[i], op); cnt[i]++; end
      if (char_last) mode[i] = M_TERM;
    end
  endtask

  task automatic model_edge(input int i);
    m_we[i] = 1'b0;
    if (reset) begin
      mode[i] = M_IDLE; cnt[i] = 0; depth[i] = 0;
      m_done[i] = 0; m_ef[i] = 0; m_eu[i] = 0; m_len[i] = 0;
    end else if (load_start && mode[i] != M_TERM) begin
      mode[i] = M_LOAD; cnt[i] = 0; depth[i] = 0;
      m_done[i] = 0; m_ef[i] = 0; m_eu[i] = 0; m_len[i] = 0;
    end else if (mode[i] == M_LOAD) begin
      if (char_valid) take_byte(i);
    end else if (mode[i] == M_TERM) begin
      emit(i, cnt[i], 15); m_len[i] = cnt[i]; m_done[i] = 1'b1; mode[i] = M_DONE;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cmp(input int i, input logic rdy, input logic we, input logic [7:0] addr,
                     input logic [3:0] din, input logic hold, input logic dn,
                     input logic ef, input logic eu, input logic [7:0] len);
    string p;
    bit xh, xr;
    p  = (i == 0) ? "big" : "small";
    xh = (mode[i] == M_LOAD) || (mode[i] == M_TERM) || (mode[i] == M_ERR);
    xr = (mode[i] == M_LOAD) && !load_start;
    chk({p, ".prog_we"}, we, m_we[i]);
    if (m_we[i]) begin
      chk({p, ".prog_addr"}, addr, m_addr[i]);
      chk({p, ".prog_din"}, din, m_din[i]);
    end
    chk({p, ".machine_hold"}, hold, xh);
    chk({p, ".char_ready"}, rdy, xr);
    chk({p, ".done"}, dn, m_done[i]);
    chk({p, ".err_full"}, ef, m_ef[i]);
    chk({p, ".err_unbal"}, eu, m_eu[i]);
    chk({p, ".prog_len"}, len, m_len[i]);
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      cmp(0, rdy0, we0, addr0, din0, hold0, done0, ef0, eu0, len0);
      cmp(1, rdy1, we1, {6'b0, addr1}, din1, hold1, done1, ef1, eu1, {6'b0, len1});
      if (we0) obs0.push_back(int'(addr0) * 16 + int'(din0));
      if (we1) obs1.push_back(int'(addr1) * 16 + int'(din1));
    end
  end

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic start(input bit with_byte);
    load_start = 1'b1;
    if (with_byte) begin char_valid = 1'b1; char_data = 8'h2B; end
    tick();
    load_start = 1'b0; char_valid = 1'b0;
  endtask

  task automatic send(input string s, input bit last, input bit gap);
    for (int k = 0; k < s.len(); k++) begin
      if (gap) begin char_valid = 1'b0; idle(2); end
      char_valid = 1'b1;
      char_data  = s[k];
      char_last  = last && (k == s.len() - 1);
      tick();
    end
    char_valid = 1'b0; char_last = 1'b0;
  endtask

  task automatic chk_seq(input string nm, input int act[$], input int exp[$]);
    chk({nm, ".count"}, act.size(), exp.size());
    for (int k = 0; k < exp.size() && k < act.size(); k++)
      chk($sformatf("%s[%0d]", nm, k), act[k], exp[k]);
  endtask

  task automatic clear();
    obs0.delete();
    obs1.delete();
  endtask

  initial begin
    int e[$];
    tick(); chk_en = 1'b1; tick();
    reset = 1'b0;
    chk("rst.prog_we", we0, 0); chk("rst.machine_hold", hold0, 0);
    chk("rst.char_ready", rdy0, 0); chk("rst.done", done0, 0);

    // Nested loop program; small memory overflows on the 4th command.
    clear(); start(0); send("+[->+<].", 1, 0); idle(3);
    e = '{'h02, 'h14, 'h23, 'h31, 'h42, 'h50, 'h65, 'h76, 'h8F};
    chk_seq("t1.writes", obs0, e);
    chk("t1.done", done0, 1); chk("t1.prog_len", len0, 8); chk("t1.hold", hold0, 0);
    e = '{'h02, 'h14, 'h23};
    chk_seq("t1.small_writes", obs1, e); chk("t1.small_err_full", ef1, 1);

    // Non-command bytes are swallowed.
    clear(); start(0); send("a +\n-", 1, 0); idle(3);
    e = '{'h02, 'h13, 'h2F};
    chk_seq("t2.writes", obs0, e); chk("t2.prog_len", len0, 2); chk("t2.done", done0, 1);

    // Overflow of the 4-slot memory: no stop, held in error.
    clear(); start(0); send("++++", 0, 0); idle(3);
    e = '{'h02, 'h12, 'h22};
    chk_seq("t3.small_writes", obs1, e);
    chk("t3.err_full", ef1, 1); chk("t3.hold", hold1, 1); chk("t3.done", done1, 0);
    e = '{'h02, 'h12, 'h22, 'h32};
    chk_seq("t3.big_writes", obs0, e);

`ifdef BF_BRACKET_CHECK_EN
    clear(); start(0); send("]", 0, 0); idle(2);
    chk("t4.err_unbal", eu0, 1); chk("t4.no_write", obs0.size(), 0); chk("t4.hold", hold0, 1);
    clear(); start(0); send("[[+]", 1, 0); idle(3);
    e = '{'h04, 'h14, 'h22};
    chk_seq("t4.open_writes", obs0, e); chk("t4.open_unbal", eu0, 1); chk("t4.open_done", done0, 0);
`endif

    // Reset in the middle of a load, then a clean reload.
    clear(); start(0); send("+-<", 0, 0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t5.prog_we", we0, 0); chk("t5.hold", hold0, 0); chk("t5.done", done0, 0);
    chk("t5.prog_addr", addr0, 0); chk("t5.prog_din", din0, 0); chk("t5.char_ready", rdy0, 0);
    clear(); start(0); send("+.", 1, 0); idle(3);
    e = '{'h02, 'h16, 'h2F};
    chk_seq("t5.writes", obs0, e); chk("t5.prog_len", len0, 2);

    // Restart mid-load with a byte presented on the load_start cycle.
    start(0); send("++", 0, 0); idle(1);
    clear(); start(1); send("-", 1, 0); idle(3);
    e = '{'h03, 'h1F};
    chk_seq("t6.writes", obs0, e); chk("t6.prog_len", len0, 1); chk("t6.done", done0, 1);
    start(0); send("++", 0, 0); idle(1);
    clear(); start(1); send("-", 1, 1); idle(3);
    chk_seq("t6.gap_writes", obs0, e); chk("t6.gap_prog_len", len0, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
